uart_rx_os16: RTL and testbench
===============================

# uart_rx_os16

16x-oversampling UART receiver: 8 data bits, no parity, 1 stop bit, LSB first. Synchronises the asynchronous `rx` pin, detects and validates the start bit, samples each bit at mid-bit, and presents the byte on `data_out` with a sticky `ready`/`ready_clr` handshake. Framing and overrun errors are flagged. It sits at the receive end of the board UART link, next to the button-triggered transmitter, and drives the LED display path.

## Interface
- `CLK_FREQ`, 100_000_000: `clk_100m` frequency in Hz.
- `BAUD`, 115200: line rate in baud.
- `OVERSAMPLE`, 16: ticks per bit. Fixed at 16; other values are unsupported.
- `clk_100m`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  asynchronous serial input; idles high.
- `ready_clr`  in  1  one-cycle pulse; clears `ready`, `frame_err` and `overrun`.
- `data_out`  out  8  last good byte received.
- `ready`  out  1  sticky "new byte available".
- `frame_err`  out  1  sticky; stop bit was sampled low.
- `overrun`  out  1  sticky; a byte completed while `ready` was already 1.

## Operation
- **Synchroniser:** 2-flop chain on `rx`, reset value 1. All decisions use the synchronised `rx_s`.
- **Tick generator:** DIV = CLK_FREQ/(BAUD*16), truncated. DIV=54 at the defaults.
  - Counter runs freely from 0 to DIV-1.
  - `tick` is a one-cycle pulse when the counter equals DIV-1.
- **States:** IDLE, START, DATA, STOP, BREAK. All state advances happen only on `tick`.
- **IDLE:** if `rx_s`=0, go to START with sample count `sc`=0.
- **START:** increment `sc` each tick. At `sc`=7 (mid start bit):
  - `rx_s`=0: go to DATA, `sc`=0, bit index 0.
  - `rx_s`=1: treat as a false start and return to IDLE.
- **DATA:** at `sc`=15, shift `rx_s` into shift-register bit 7 (shift right, so LSB first) and reset `sc`. After the 8th bit, go to STOP.
- **STOP:** at `sc`=15, sample `rx_s`.
  - `rx_s`=1: load `data_out` from the shift register, set `ready`, go to IDLE. If `ready` was already 1, `data_out` is overwritten and `overrun` is set.
  - `rx_s`=0: set `frame_err`, leave `data_out` and `ready` unchanged, go to BREAK.
- **BREAK:** stay until `rx_s`=1, then go to IDLE. A held-low line therefore yields exactly one framing error.
- **`ready_clr`:** clears `ready`, `frame_err` and `overrun` on the next edge.
  - If a completion sets a flag in the same cycle, the set wins.
  - `overrun` is not raised when `ready_clr` coincides with completion.
- **Reset:** returns to IDLE from any state, including mid-frame; the partial byte is discarded.

## Timing
- Reset values: `data_out`=0x00, `ready`=0, `frame_err`=0, `overrun`=0, state IDLE, synchroniser 1, tick counter 0, `sc`=0.
- Pin to `rx_s` delay: 2 cycles.
- Start-edge detection jitter: up to 1 tick (DIV cycles).
- Latency from the `rx` falling edge to `ready`=1: 2 + (8 + 16×9)×DIV cycles, with up to DIV cycles of additional jitter. That is 9.5 bit times.
- `ready`, `frame_err` and `overrun` are registered and change only on the `clk_100m` edge following the deciding tick.
- The receiver is back in IDLE half a bit before the nominal stop-bit end. A back-to-back start bit is therefore accepted with no idle gap.
- Tolerated rate error: ±3% combined, including DIV truncation (0.46% at the defaults).

## Structure
- **Package `uart_pkg`:**
  - state enum `rx_state_t` (IDLE/START/DATA/STOP/BREAK);
  - constants `DATA_BITS`=8, `OS_RATE`=16, `OS_MID`=7;
  - function `baud_div(clk, baud)`.
- **Sub-module `uart_baud_tick`:** parameterised divider producing the `tick` pulse. It is shareable with the transmitter.
- **Top of this block:** synchroniser, FSM, shift register and flag logic.

## Test plan
Benches use CLK_FREQ=1_600_000 and BAUD=10_000, giving DIV=10 and 160 cycles per bit.

1. **Good frame:** send 0xA5 with a valid stop bit. Require `data_out`=0xA5, `ready`=1 within 2+1520+10 cycles of the falling edge, and `frame_err`=0.
2. **Glitch:** drive `rx` low for 30 cycles, then high. Require no `ready`, FSM back in IDLE, then a following 0x5A frame received correctly.
3. **Framing error:** send 0x3C with the stop bit low, then hold low for 3 bit times. Require `frame_err`=1 exactly once, `ready`=0 and `data_out` unchanged. Then release high and send 0x81: `data_out`=0x81.
4. **Overrun:** send 0x11 then 0x22 back to back without `ready_clr`. Require `data_out`=0x22, `ready`=1 and `overrun`=1. Then pulse `ready_clr`: all three flags return to 0.
5. **Clear/set collision:** pulse `ready_clr` in the same cycle as 0x7E completion, with `ready` previously 1. Require `ready`=1, `data_out`=0x7E and `overrun`=0.
6. **Reset mid-frame:** assert `rst` during bit 4 of 0xF0. Require every output at its reset value. Then send 0x0F: `data_out`=0x0F, `ready`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t  receiver FSM state encoding
//   DATA_BITS   payload bits per frame
//   OS_RATE     oversampling ticks per bit
//   OS_MID      sample count at which the start bit is at its centre
//   baud_div()  clock cycles per oversampling tick (truncated)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int OS_RATE   = 16;
    localparam int OS_MID    = 7;

    function automatic int baud_div(input int clk, input int baud);
        return clk / (baud * OS_RATE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider that emits one single-cycle tick
// every DIV clocks. Shared by the UART transmitter and receiver.
//   clk_100m  in   system clock
//   rst       in   synchronous active-high reset
//   tick      out  one-cycle pulse, period DIV cycles
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk_100m,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Wrap counter 0..DIV-1; tick is registered so it lags the wrap by one
    // cycle, which only shifts the tick phase and never its period.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            tick_r <= (cnt_r == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling UART receiver, 8N1, LSB first.
//   clk_100m   in   system clock (only clock)
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idles high
//   ready_clr  in   one-cycle pulse clearing ready/frame_err/overrun
//   data_out   out  last good byte
//   ready      out  sticky new-byte flag
//   frame_err  out  sticky stop-bit-low flag
//   overrun    out  sticky byte-completed-while-ready flag
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_100m,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready_clr,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int         DIV      = baud_div(CLK_FREQ, BAUD);
    localparam logic [3:0] SC_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SC_MID   = 4'(OS_MID);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic                 tick_s;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    rx_state_t            state_r;
    logic [3:0]           sc_r;
    logic [2:0]           bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [7:0]           data_r;
    logic                 ready_r;
    logic                 frame_err_r;
    logic                 overrun_r;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_100m (clk_100m),
        .rst      (rst),
        .tick     (tick_s)
    );

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM, shift register and sticky flags. The clear is written
    // first so that a same-cycle completion overrides it.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_r     <= IDLE;
            sc_r        <= 4'd0;
            bit_idx_r   <= 3'd0;
            shift_r     <= '0;
            data_r      <= 8'h00;
            ready_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (ready_clr) begin
                ready_r     <= 1'b0;
                frame_err_r <= 1'b0;
                overrun_r   <= 1'b0;
            end
            if (tick_s) begin
                case (state_r)
                    IDLE: begin
                        sc_r <= 4'd0;
                        if (!rx_sync_r) begin
                            state_r <= START;
                        end
                    end
                    START: begin
                        // Re-check the line at mid start bit to reject glitches.
                        if (sc_r == SC_MID) begin
                            sc_r      <= 4'd0;
                            bit_idx_r <= 3'd0;
                            state_r   <= rx_sync_r ? IDLE : DATA;
                        end else begin
                            sc_r <= sc_r + 4'd1;
                        end
                    end
                    DATA: begin
                        if (sc_r == SC_LAST) begin
                            sc_r    <= 4'd0;
                            shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                            if (bit_idx_r == BIT_LAST) begin
                                state_r <= STOP;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            sc_r <= sc_r + 4'd1;
                        end
                    end
                    STOP: begin
                        if (sc_r == SC_LAST) begin
                            sc_r <= 4'd0;
                            if (rx_sync_r) begin
                                data_r  <= shift_r;
                                ready_r <= 1'b1;
                                // A clear arriving with the new byte means the
                                // previous one was consumed: no overrun.
                                if (ready_r && !ready_clr) begin
                                    overrun_r <= 1'b1;
                                end
                                state_r <= IDLE;
                            end else begin
                                frame_err_r <= 1'b1;
                                state_r     <= BREAK;
                            end
                        end else begin
                            sc_r <= sc_r + 4'd1;
                        end
                    end
                    BREAK: begin
                        // Wait out a held-low line so it reports one error only.
                        sc_r <= 4'd0;
                        if (rx_sync_r) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        sc_r    <= 4'd0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out  = data_r;
    assign ready     = ready_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: scoreboard bench for uart_rx_os16 at 160 cycles per bit.
// A stimulus-side model pushes the expected output state for each frame;
// a monitor pops and compares whenever the DUT reports a new byte or error.
module tb_uart_rx_os16;
    import uart_pkg::*;

    localparam int BIT_CYC = 160;

    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk_100m  = 1'b0;
    logic       rst       = 1'b1;
    logic       rx        = 1'b1;
    logic       ready_clr = 1'b0;
    logic [7:0] data_out;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   rise_cyc = 0;
    int   fe_rises = 0;
    exp_t exp_q[$];

    // Reference state: what the outputs must read after the next completion.
    logic [7:0] m_data  = 8'h00;
    logic       m_ready = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_ov    = 1'b0;

    uart_rx_os16 #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk_100m  (clk_100m),
        .rst       (rst),
        .rx        (rx),
        .ready_clr (ready_clr),
        .data_out  (data_out),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // 100 MHz-style free clock (period 10 time units).
    always #5 clk_100m = ~clk_100m;

    // Cycle counter for latency measurement.
    always @(posedge clk_100m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    // Frame outcome from the protocol rules: a good stop delivers the byte
    // (overrun if the old one is unread), a bad stop only flags the error.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit clr_coinc);
        if (stop_ok) begin
            if (clr_coinc) begin
                m_fe = 1'b0;
                m_ov = 1'b0;
            end else if (m_ready) begin
                m_ov = 1'b1;
            end
            m_data  = b;
            m_ready = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
        exp_q.push_back('{data: m_data, rdy: m_ready, fe: m_fe, ov: m_ov});
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit clr_coinc);
        model_frame(b, stop_ok, clr_coinc);
        fall_cyc = cyc;
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk_100m);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk_100m);
        end
        rx = stop_ok;
        repeat (BIT_CYC) @(negedge clk_100m);
    endtask

    task automatic pulse_clr();
        ready_clr = 1'b1;
        @(negedge clk_100m);
        ready_clr = 1'b0;
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk_100m);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expected events never seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Raise ready_clr for exactly the cycle in which the stop bit is accepted.
    task automatic collide();
        bit hit = 1'b0;
        for (int i = 0; i < 2500 && !hit; i++) begin
            @(negedge clk_100m);
            if (dut.state_r == STOP && dut.sc_r == 4'd15 && dut.tick_s) begin
                ready_clr = 1'b1;
                @(negedge clk_100m);
                ready_clr = 1'b0;
                hit = 1'b1;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL collide_timeout: completion point not found, got 0 expected 1");
        end
    endtask

    // Monitor: detects new byte / new error / overwritten byte and scores it.
    initial begin
        logic       prev_r  = 1'b0;
        logic       prev_fe = 1'b0;
        logic [7:0] prev_d  = 8'h00;
        bit         ev;
        exp_t       e;
        forever begin
            @(negedge clk_100m);
            if (!rst) begin
                ev = (ready && !prev_r) || (frame_err && !prev_fe) ||
                     (ready && prev_r && data_out != prev_d);
                if (frame_err && !prev_fe) fe_rises++;
                if (ready && !prev_r) rise_cyc = cyc;
                if (ev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: data=%02h ready=%0b fe=%0b ov=%0b, expected none",
                                 data_out, ready, frame_err, overrun);
                    end else begin
                        e = exp_q.pop_front();
                        check("event{data,ready,fe,ov}", {21'd0, data_out, ready, frame_err, overrun},
                              {21'd0, e});
                    end
                end
            end
            prev_r  = ready;
            prev_fe = frame_err;
            prev_d  = data_out;
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] f0 = 8'hF0;
        bit         ok;
        int         fe_base;

        // Reset state
        repeat (5) @(negedge clk_100m);
        check("rst_data", {24'd0, data_out}, 32'h00);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        check("rst_ov", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk_100m);

        // 1: good frame with latency bound
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_drain();
        check_range("latency_A5", rise_cyc - fall_cyc, 1520, 2 + 1520 + 10);
        check("good_data", {24'd0, data_out}, 32'hA5);
        check("good_fe", {31'd0, frame_err}, 32'd0);

        // 2: 30-cycle glitch must be rejected
        pulse_clr();
        rx = 1'b0;
        repeat (30) @(negedge clk_100m);
        rx = 1'b1;
        repeat (200) @(negedge clk_100m);
        check("glitch_idle", {29'd0, dut.state_r}, {29'd0, IDLE});
        check("glitch_ready", {31'd0, ready}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_drain();

        // 3: framing error on a held-low line
        pulse_clr();
        fe_base = fe_rises;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3 * BIT_CYC) @(negedge clk_100m);
        wait_drain();
        check("fe_once", fe_rises - fe_base, 32'd1);
        check("fe_ready", {31'd0, ready}, 32'd0);
        check("fe_data", {24'd0, data_out}, 32'h5A);
        rx = 1'b1;
        repeat (BIT_CYC) @(negedge clk_100m);
        pulse_clr();
        send_frame(8'h81, 1'b1, 1'b0);
        wait_drain();
        check("after_fe_data", {24'd0, data_out}, 32'h81);

        // 4: overrun on back-to-back frames, then clear
        pulse_clr();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_drain();
        check("ovr_data", {24'd0, data_out}, 32'h22);
        check("ovr_ready", {31'd0, ready}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        pulse_clr();
        check("clr_flags", {29'd0, ready, frame_err, overrun}, 32'd0);

        // 5: clear coinciding with completion, ready previously set
        send_frame(8'h33, 1'b1, 1'b0);
        wait_drain();
        fork
            send_frame(8'h7E, 1'b1, 1'b1);
            collide();
        join
        wait_drain();
        check("coll_ready", {31'd0, ready}, 32'd1);
        check("coll_data", {24'd0, data_out}, 32'h7E);
        check("coll_ov", {31'd0, overrun}, 32'd0);

        // 6: reset during bit 4 of 0xF0
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk_100m);
        for (int i = 0; i < 4; i++) begin
            rx = f0[i];
            repeat (BIT_CYC) @(negedge clk_100m);
        end
        rx = f0[4];
        repeat (BIT_CYC / 2) @(negedge clk_100m);
        rst = 1'b1;
        repeat (3) @(negedge clk_100m);
        rst = 1'b0;
        rx  = 1'b1;
        m_data = 8'h00; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        @(negedge clk_100m);
        check("mid_rst_outs", {20'd0, data_out, ready, frame_err, overrun}, 32'd0);
        check("mid_rst_state", {29'd0, dut.state_r}, {29'd0, IDLE});
        repeat (2 * BIT_CYC) @(negedge clk_100m);
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_drain();
        check("post_rst_data", {24'd0, data_out}, 32'h0F);
        check("post_rst_ready", {31'd0, ready}, 32'd1);

        // Randomized frames: random bytes, gaps, stop errors and clears
        for (int n = 0; n < 12; n++) begin
            ok = ($urandom_range(0, 4) != 0);
            if (!ok && m_fe) pulse_clr();
            do b = 8'($urandom); while (ok && m_ready && b == m_data);
            repeat ($urandom_range(0, 300)) @(negedge clk_100m);
            send_frame(b, ok, 1'b0);
            if (!ok) begin
                repeat ($urandom_range(1, 3) * BIT_CYC) @(negedge clk_100m);
                rx = 1'b1;
                repeat (BIT_CYC) @(negedge clk_100m);
            end
            wait_drain();
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end

        repeat (400) @(negedge clk_100m);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
